// File: rtl/throw_hit_detect.sv
// Throw hit detector: follows a projectile trajectory (distance/height from
// the throw origin), converts it to screen coordinates and decides whether
// the throw hit the target box, landed short, left the screen or stalled.
// The outcome is offered on a valid/ready result port and accepted hits are
// tallied in a saturating score counter.
module throw_hit_detect #(
    parameter int ORIGIN_X = 64,
    parameter int GROUND_Y = 700,
    parameter int TARGET_W = 32,
    parameter int TARGET_H = 48,
    parameter int X_LIMIT  = 1023,
    parameter int TIMEOUT  = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic [11:0] target_x,
    input  logic        clear_score,
    input  logic        res_ready,
    output logic        res_valid,
    output logic        res_hit,
    output logic [11:0] scr_x,
    output logic [11:0] scr_y,
    output logic        busy,
    output logic [7:0]  hit_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FLIGHT = 2'd2,
        RESULT = 2'd3
    } state_t;

    // Position pipeline and screen-coordinate registers
    logic [11:0] px_q, py_q;
    logic [11:0] px_prev_q, py_prev_q;
    logic [11:0] scr_x_q, scr_x_d;
    logic [11:0] scr_y_q, scr_y_d;

    // Control state
    state_t      state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        res_hit_q, res_hit_d;
    logic [7:0]  hit_count_q, hit_count_d;

    // Derived evaluation terms (all based on the registered px/py)
    logic [12:0] sum_x;
    logic [11:0] sx_sat;
    logic [12:0] tgt_lo;
    logic [12:0] tgt_hi;
    logic        in_box;
    logic        at_zero;
    logic        pos_same;
    logic        off_screen;
    logic        timed_out;
    logic [TW-1:0] tmo_step;

    // Screen mapping and hit/miss condition decode
    always_comb begin
        sum_x      = 13'(ORIGIN_X) + {1'b0, px_q};
        sx_sat     = sum_x[12] ? 12'hFFF : sum_x[11:0];
        scr_x_d    = sx_sat;
        scr_y_d    = (py_q <= 12'(GROUND_Y)) ? (12'(GROUND_Y) - py_q) : 12'd0;
        // Target bounds kept at 13 bits so a box near the right edge never wraps
        tgt_lo     = {1'b0, target_x};
        tgt_hi     = tgt_lo + 13'(TARGET_W - 1);
        in_box     = ({1'b0, sx_sat} >= tgt_lo) && ({1'b0, sx_sat} <= tgt_hi)
                     && (py_q < 12'(TARGET_H));
        at_zero    = (px_q == 12'd0) && (py_q == 12'd0);
        pos_same   = (px_q == px_prev_q) && (py_q == py_prev_q);
        off_screen = sum_x > 13'(X_LIMIT);
        // Stall counter only advances while the position is frozen
        tmo_step   = pos_same ? (tmo_q + TW'(1)) : '0;
        timed_out  = pos_same && (tmo_q == TW'(TIMEOUT - 1));
    end

    // Input stage and registered screen coordinates
    always_ff @(posedge clk) begin
        if (rst) begin
            px_q      <= '0;
            py_q      <= '0;
            px_prev_q <= '0;
            py_prev_q <= '0;
            scr_x_q   <= 12'(ORIGIN_X);
            scr_y_q   <= 12'(GROUND_Y);
        end else begin
            px_q      <= x_pos;
            py_q      <= y_pos;
            px_prev_q <= px_q;
            py_prev_q <= py_q;
            scr_x_q   <= scr_x_d;
            scr_y_q   <= scr_y_d;
        end
    end

    // Next-state, result and score logic
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        res_hit_d   = res_hit_q;
        hit_count_d = hit_count_q;
        case (state_q)
            IDLE: begin
                // Position is ignored here; the trajectory stage may still be idle
                if (start) begin
                    state_d = ARMED;
                    tmo_d   = '0;
                end
            end
            ARMED: begin
                tmo_d = tmo_step;
                if (!at_zero) begin
                    state_d = FLIGHT;
                end else if (timed_out) begin
                    state_d   = RESULT;
                    res_hit_d = 1'b0;
                end
            end
            FLIGHT: begin
                tmo_d = tmo_step;
                // A hit wins over any simultaneous miss condition
                if (in_box) begin
                    state_d   = RESULT;
                    res_hit_d = 1'b1;
                end else if (at_zero || off_screen || timed_out) begin
                    state_d   = RESULT;
                    res_hit_d = 1'b0;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                    if (res_hit_q && (hit_count_q != 8'hFF)) begin
                        hit_count_d = hit_count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear_score) begin
            hit_count_d = 8'd0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            res_hit_q   <= 1'b0;
            hit_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            res_hit_q   <= res_hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign res_valid = (state_q == RESULT);
    assign res_hit   = res_hit_q;
    assign busy      = (state_q != IDLE);
    assign scr_x     = scr_x_q;
    assign scr_y     = scr_y_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_throw_hit_detect.sv
// Directed bench for throw_hit_detect: screen mapping, hit, miss-land,
// off-screen, backpressure/priority, timeout, saturation and reset.
module tb_throw_hit_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic [11:0] target_x;
    logic        clear_score;
    logic        res_ready;
    logic        res_valid;
    logic        res_hit;
    logic [11:0] scr_x;
    logic [11:0] scr_y;
    logic        busy;
    logic [7:0]  hit_count;

    int n_chk  = 0;
    int n_pass = 0;

    throw_hit_detect dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .target_x   (target_x),
        .clear_score(clear_score),
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .res_hit    (res_hit),
        .scr_x      (scr_x),
        .scr_y      (scr_y),
        .busy       (busy),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Throw from a held (140,30) position against target_x=200: ARMED, FLIGHT,
    // then RESULT with a hit three edges after the start edge.
    task automatic throw_hit();
        start = 1'b1;
        step();
        start = 1'b0;
        x_pos = 12'd140;
        y_pos = 12'd30;
        step();
        step();
        step();
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; x_pos = '0; y_pos = '0; target_x = '0;
        clear_score = 1'b0; res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_hit", 32'(res_hit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(hit_count), 32'd0);
        chk("rst_scr_x", 32'(scr_x), 32'd64);
        chk("rst_scr_y", 32'(scr_y), 32'd700);

        // Screen mapping with two-cycle latency
        x_pos = 12'd100; y_pos = 12'd200;
        step();
        chk("scr_x_lat", 32'(scr_x), 32'd64);
        step();
        chk("scr_x_map", 32'(scr_x), 32'd164);
        chk("scr_y_map", 32'(scr_y), 32'd500);
        x_pos = 12'd4095; y_pos = 12'd800;
        step();
        step();
        chk("scr_x_sat", 32'(scr_x), 32'd4095);
        chk("scr_y_below", 32'(scr_y), 32'd0);
        x_pos = '0; y_pos = '0;
        step();
        step();

        // Hit: ramp to 200, dipping into the box at x=140
        target_x = 12'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int v = 10; v <= 200; v += 10) begin
            x_pos = 12'(v);
            y_pos = (v == 140) ? 12'd30 : 12'd100;
            step();
            if (v == 140) chk("hit_not_yet", 32'(res_valid), 32'd0);
            if (v == 150) begin
                chk("hit_valid", 32'(res_valid), 32'd1);
                chk("hit_hit", 32'(res_hit), 32'd1);
                chk("hit_busy", 32'(busy), 32'd1);
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("hit_ack_valid", 32'(res_valid), 32'd0);
        chk("hit_ack_busy", 32'(busy), 32'd0);
        chk("hit_ack_count", 32'(hit_count), 32'd1);
        x_pos = '0; y_pos = '0;
        step();

        // Miss-land: return to (0,0) after x=300
        target_x = 12'd600;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int v = 10; v <= 300; v += 10) begin
            x_pos = 12'(v);
            y_pos = 12'd50;
            step();
        end
        x_pos = '0; y_pos = '0;
        step();
        chk("land_not_yet", 32'(res_valid), 32'd0);
        step();
        chk("land_valid", 32'(res_valid), 32'd1);
        chk("land_hit", 32'(res_hit), 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("land_count", 32'(hit_count), 32'd1);

        // Off-screen: x reaches 960 (screen x 1024)
        target_x = 12'd2000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int v = 60; v <= 960; v += 60) begin
            x_pos = 12'(v);
            y_pos = 12'd100;
            step();
        end
        chk("off_not_yet", 32'(res_valid), 32'd0);
        step();
        chk("off_valid", 32'(res_valid), 32'd1);
        chk("off_hit", 32'(res_hit), 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("off_count", 32'(hit_count), 32'd1);

        // Backpressure, ignored start, clear_score priority
        target_x = 12'd200;
        throw_hit();
        for (int c = 0; c < 20; c++) begin
            start = (c == 10);
            step();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_hit", 32'(res_hit), 32'd1);
        end
        start = 1'b1; res_ready = 1'b1; clear_score = 1'b1;
        step();
        start = 1'b0; res_ready = 1'b0; clear_score = 1'b0;
        chk("clr_count", 32'(hit_count), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_valid", 32'(res_valid), 32'd0);

        // Timeout with frozen (0,0) inputs
        x_pos = '0; y_pos = '0;
        step();
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!res_valid && n < 5000) begin
            step();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd4095);
        chk("tmo_hit", 32'(res_hit), 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("tmo_count", 32'(hit_count), 32'd0);

        // Saturation: 256 accepted hits
        for (int k = 1; k <= 256; k++) begin
            throw_hit();
            chk("sat_valid", 32'(res_valid & res_hit), 32'd1);
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            if (k == 255) chk("sat_255", 32'(hit_count), 32'd255);
        end
        chk("sat_hold", 32'(hit_count), 32'd255);

        // Reset mid-flight
        x_pos = '0; y_pos = '0;
        step();
        target_x = 12'd2000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int v = 10; v <= 30; v += 10) begin
            x_pos = 12'(v);
            y_pos = 12'd100;
            step();
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_hit", 32'(res_hit), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(hit_count), 32'd0);
        chk("mid_rst_scr_x", 32'(scr_x), 32'd64);
        chk("mid_rst_scr_y", 32'(scr_y), 32'd700);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/throw_hit_detect.md
THROW_HIT_DETECT -- requirements
Module: throw_hit_detect

Interface
REQ-001 Parameter ORIGIN_X, default 64, screen x of the throw origin in pixels.
REQ-002 Parameter GROUND_Y, default 700, screen y of the ground line in pixels.
REQ-003 Parameter TARGET_W, default 32, target box width in pixels.
REQ-004 Parameter TARGET_H, default 48, target box height above ground in pixels.
REQ-005 Parameter X_LIMIT, default 1023, maximum on-screen x in pixels.
REQ-006 Parameter TIMEOUT, default 4095, idle-position cycle limit.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  single-cycle pulse when a throw is launched (same pulse that enables the trajectory stage).
REQ-010 x_pos  in  12  trajectory horizontal distance from origin.
REQ-011 y_pos  in  12  trajectory height above ground.
REQ-012 target_x  in  12  screen x of the target box left edge.
REQ-013 clear_score  in  1  clear hit_count.
REQ-014 res_ready  in  1  consumer accepts the result.
REQ-015 res_valid  out  1  result available.
REQ-016 res_hit  out  1  1 = hit, 0 = miss; meaningful only while res_valid.
REQ-017 scr_x  out  12  projectile screen x, registered.
REQ-018 scr_y  out  12  projectile screen y, registered.
REQ-019 busy  out  1  high in ARMED, FLIGHT, and RESULT.
REQ-020 hit_count  out  8  accepted hits, saturating.

Function
REQ-021 Input stage SHALL register x_pos/y_pos each cycle into px/py (1-cycle latency); all evaluation uses px/py.
REQ-022 scr_x SHALL be min(ORIGIN_X+px, 4095) computed at 13 bits; scr_y SHALL be GROUND_Y-py when py<=GROUND_Y, else 0; both registered from px/py (2-cycle latency from inputs).
REQ-023 FSM states SHALL be IDLE, ARMED, FLIGHT, and RESULT.
REQ-024 IDLE: on start go to ARMED, clear the timeout counter, and ignore position.
REQ-025 ARMED: go to FLIGHT when (px,py) != (0,0).
REQ-026 FLIGHT hit: scr_x in [target_x, target_x+TARGET_W-1] (13-bit compare, no wrap) and py < TARGET_H.
REQ-027 FLIGHT miss-land: (px,py) == (0,0), which is the trajectory stage returning to idle.
REQ-028 FLIGHT miss-off-screen: ORIGIN_X+px > X_LIMIT.
REQ-029 Any hit, miss-land, or miss-off-screen condition in FLIGHT SHALL go to RESULT next cycle with res_hit set accordingly.
REQ-030 Hit SHALL take priority over both miss conditions when they occur in the same cycle.
REQ-031 Timeout: in ARMED/FLIGHT the counter increments each cycle that (px,py) is unchanged from the previous cycle and clears on change; reaching TIMEOUT SHALL go to RESULT with res_hit=0.
REQ-032 RESULT: res_valid=1, with res_hit held stable until res_ready.
REQ-033 Handshake in the cycle with res_valid && res_ready: go to IDLE next cycle, deassert res_valid, and increment hit_count if res_hit (saturating at 255).
REQ-034 start outside IDLE SHALL be ignored, including in the same cycle as a handshake.
REQ-035 clear_score SHALL zero hit_count next cycle and take priority over a simultaneous increment.
REQ-036 target_x is sampled continuously; changes mid-flight apply from the next evaluation.

Reset
REQ-037 rst SHALL force IDLE and set res_valid=0, res_hit=0, busy=0, hit_count=0, px=py=0, scr_x=ORIGIN_X, scr_y=GROUND_Y, and the timeout counter to 0.
REQ-038 rst mid-flight or in RESULT SHALL discard the pending result without incrementing hit_count.

Verification
REQ-039 Hit: target_x=200, start, then ramp x_pos 0->200 by 10 per cycle with y_pos=30 at x_pos=140 -> res_valid=1, res_hit=1; with res_ready=1 -> hit_count=1 and IDLE.
REQ-040 Miss-land: target_x=600, trajectory returns to (0,0) at x_pos=300 -> res_hit=0, hit_count unchanged.
REQ-041 Off-screen: x_pos reaching 960 (ORIGIN_X+px=1024) with target_x=2000 -> res_hit=0 miss.
REQ-042 Backpressure and priority: hold res_ready=0 for 20 cycles -> res_valid and res_hit stable; pulse start -> ignored; clear_score together with an accepted hit -> hit_count=0.
REQ-043 Timeout and reset: start with inputs frozen at (0,0) -> res_hit=0 miss after TIMEOUT cycles; assert rst in FLIGHT -> all outputs at reset values next cycle.
REQ-044 Saturation: 256 accepted hits -> hit_count=255.
